// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice allocation path.
package synth_pkg;

  localparam int unsigned NUM_VOICES_DEF = 128;

  typedef enum logic [1:0] {
    EV_ON    = 2'd0,
    EV_OFF   = 2'd1,
    EV_PRESS = 2'd2,
    EV_NONE  = 2'd3
  } ev_type_e;

  typedef enum logic [1:0] {
    VA_IDLE  = 2'd0,
    VA_SCAN  = 2'd1,
    VA_ISSUE = 2'd2
  } va_state_e;

  // Outcome of a scan, acted on in the ISSUE cycle.
  typedef enum logic [1:0] {
    ACT_NONE    = 2'd0,
    ACT_PRESS   = 2'd1,
    ACT_RELEASE = 2'd2,
    ACT_KEY     = 2'd3
  } va_act_e;

endpackage

// File: rtl/voice_table.sv
// Per-slot owner/state register file: one combinational read port, one ISSUE write port
// and a voice_done clear port that loses to a same-slot ISSUE write.
module voice_table
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic              clk32,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_busy,
  output logic              rd_held,
  output logic [3:0]        rd_ch,
  output logic [6:0]        rd_nt,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic              wr_held,
  input  logic [3:0]        wr_ch,
  input  logic [6:0]        wr_nt,
  output logic              wr_free,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic              clr_eff
);

  logic [NUM_VOICES-1:0] busy_q;
  logic [NUM_VOICES-1:0] held_q;
  logic [3:0]            ch_q [NUM_VOICES];
  logic [6:0]            nt_q [NUM_VOICES];
  logic [IDX_W-1:0]      clr_idx;

  assign clr_idx = clr_addr[IDX_W-1:0];

  always_comb begin
    rd_busy = busy_q[rd_idx];
    rd_held = held_q[rd_idx];
    rd_ch   = ch_q[rd_idx];
    rd_nt   = nt_q[rd_idx];
    wr_free = !busy_q[wr_addr];
    // A clear only counts when it really frees a busy slot the ISSUE write is not claiming.
    clr_eff = clr_en && (32'(clr_addr) < NUM_VOICES) && busy_q[clr_idx] &&
              !(wr_en && (wr_addr == clr_idx));
  end

  always_ff @(posedge clk32) begin
    if (rst) begin
      busy_q <= '0;
      held_q <= '0;
    end else begin
      if (clr_eff) begin
        busy_q[clr_idx] <= 1'b0;
        held_q[clr_idx] <= 1'b0;
      end
      if (wr_en) begin
        busy_q[wr_addr] <= 1'b1;
        held_q[wr_addr] <= wr_held;
      end
    end
  end

  always_ff @(posedge clk32) begin
    if (wr_en) begin
      ch_q[wr_addr] <= wr_ch;
      nt_q[wr_addr] <= wr_nt;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Maps MIDI note events onto voice slots by linear scan; optional round-robin stealing
// when every slot is held is enabled by defining VOICE_STEAL_EN.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk32,
  input  logic              rst,
  input  logic              ev_valid,
  output logic              ev_ready,
  input  logic [1:0]        ev_type,
  input  logic [6:0]        ev_note,
  input  logic [6:0]        ev_velocity,
  input  logic [3:0]        ev_channel,
  input  logic              voice_done,
  input  logic [ADDR_W-1:0] voice_done_addr,
  output logic              note_pressed,
  output logic              note_released,
  output logic              note_keypress,
  output logic [6:0]        note,
  output logic [6:0]        velocity,
  output logic [3:0]        channel,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        active_count,
  output logic              drop_pulse
);

  localparam int unsigned      IDX_W   = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_VOICES - 1);
  localparam logic [7:0]       MAX_CNT = 8'(NUM_VOICES);

  va_state_e        state_q, state_d;
  ev_type_e         typ_in, typ_q;
  logic [6:0]       ev_note_q, ev_vel_q;
  logic [3:0]       ev_ch_q;
  logic [IDX_W-1:0] idx_q, free_idx_q, rel_idx_q, dec_idx;
  logic             free_found_q, rel_found_q;
  va_act_e          act_q, dec_act;
  logic [6:0]       note_q, velocity_q;
  logic [3:0]       channel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]       count_q;
  logic             accept, cur_match, scan_end;
  logic             rd_busy, rd_held, wr_en, wr_free, clr_eff, inc;
  logic [3:0]       rd_ch;
  logic [6:0]       rd_nt;
`ifdef VOICE_STEAL_EN
  logic [IDX_W-1:0] steal_ptr_q;
  logic             steal_q, dec_steal;
`endif

  voice_table #(
    .NUM_VOICES(NUM_VOICES),
    .ADDR_W    (ADDR_W),
    .IDX_W     (IDX_W)
  ) u_table (
    .clk32   (clk32),
    .rst     (rst),
    .rd_idx  (idx_q),
    .rd_busy (rd_busy),
    .rd_held (rd_held),
    .rd_ch   (rd_ch),
    .rd_nt   (rd_nt),
    .wr_en   (wr_en),
    .wr_addr (addr_q[IDX_W-1:0]),
    .wr_held (act_q == ACT_PRESS),
    .wr_ch   (ev_ch_q),
    .wr_nt   (ev_note_q),
    .wr_free (wr_free),
    .clr_en  (voice_done),
    .clr_addr(voice_done_addr),
    .clr_eff (clr_eff)
  );

  always_comb begin
    typ_in = ev_type_e'(ev_type);
    if (typ_in == EV_ON && ev_velocity == 7'd0) typ_in = EV_OFF;
    accept    = ev_valid && ev_ready;
    cur_match = rd_held && (rd_ch == ev_ch_q) && (rd_nt == ev_note_q);
    scan_end  = (state_q == VA_SCAN) && (cur_match || idx_q == LAST);
    wr_en     = (state_q == VA_ISSUE) && (act_q == ACT_PRESS || act_q == ACT_RELEASE);
    inc       = wr_en && (act_q == ACT_PRESS) && wr_free;
  end

  // Decision taken on the final scan cycle, including the slot being read right now.
  always_comb begin
    dec_act = ACT_NONE;
    dec_idx = idx_q;
`ifdef VOICE_STEAL_EN
    dec_steal = 1'b0;
`endif
    if (typ_q == EV_ON) begin
      if (cur_match) begin
        dec_act = ACT_PRESS;
      end else if (free_found_q || !rd_busy) begin
        dec_act = ACT_PRESS;
        dec_idx = free_found_q ? free_idx_q : idx_q;
      end else if (rel_found_q || !rd_held) begin
        dec_act = ACT_PRESS;
        dec_idx = rel_found_q ? rel_idx_q : idx_q;
      end
`ifdef VOICE_STEAL_EN
      else begin
        dec_act   = ACT_PRESS;
        dec_idx   = steal_ptr_q;
        dec_steal = 1'b1;
      end
`endif
    end else if (cur_match) begin
      dec_act = (typ_q == EV_OFF) ? ACT_RELEASE : ACT_KEY;
    end
  end

  always_ff @(posedge clk32) begin
    if (rst) state_q <= VA_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      VA_IDLE:  if (accept && typ_in != EV_NONE) state_d = VA_SCAN;
      VA_SCAN:  if (scan_end) state_d = VA_ISSUE;
      default:  state_d = VA_IDLE;
    endcase
  end

  always_comb begin
    ev_ready      = (state_q == VA_IDLE) && !rst;
    note_pressed  = 1'b0;
    note_released = 1'b0;
    note_keypress = 1'b0;
    drop_pulse    = 1'b0;
    if (state_q == VA_ISSUE) begin
      unique case (act_q)
        ACT_PRESS:   note_pressed  = 1'b1;
        ACT_RELEASE: note_released = 1'b1;
        ACT_KEY:     note_keypress = 1'b1;
        default:     drop_pulse    = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk32) begin
    if (rst) begin
      typ_q        <= EV_NONE;
      ev_note_q    <= '0;
      ev_vel_q     <= '0;
      ev_ch_q      <= '0;
      idx_q        <= '0;
      free_idx_q   <= '0;
      rel_idx_q    <= '0;
      free_found_q <= 1'b0;
      rel_found_q  <= 1'b0;
      act_q        <= ACT_NONE;
      note_q       <= '0;
      velocity_q   <= '0;
      channel_q    <= '0;
      addr_q       <= '0;
      count_q      <= '0;
    end else begin
      if (accept) begin
        typ_q        <= typ_in;
        ev_note_q    <= ev_note;
        ev_vel_q     <= ev_velocity;
        ev_ch_q      <= ev_channel;
        idx_q        <= '0;
        free_found_q <= 1'b0;
        rel_found_q  <= 1'b0;
      end
      if (state_q == VA_SCAN) begin
        idx_q <= idx_q + 1'b1;
        if (!free_found_q && !rd_busy) begin
          free_found_q <= 1'b1;
          free_idx_q   <= idx_q;
        end
        if (!rel_found_q && rd_busy && !rd_held) begin
          rel_found_q <= 1'b1;
          rel_idx_q   <= idx_q;
        end
      end
      if (scan_end) begin
        act_q <= dec_act;
        // Output fields only move on a real strobe so they hold between strobes.
        if (dec_act != ACT_NONE) begin
          note_q     <= ev_note_q;
          velocity_q <= ev_vel_q;
          channel_q  <= ev_ch_q;
          addr_q     <= ADDR_W'(dec_idx);
        end
      end
      if (inc && !clr_eff && count_q != MAX_CNT) count_q <= count_q + 8'd1;
      else if (clr_eff && !inc && count_q != 8'd0) count_q <= count_q - 8'd1;
    end
  end

`ifdef VOICE_STEAL_EN
  always_ff @(posedge clk32) begin
    if (rst) begin
      steal_ptr_q <= '0;
      steal_q     <= 1'b0;
    end else begin
      if (scan_end) steal_q <= dec_steal;
      if (state_q == VA_ISSUE && steal_q) begin
        steal_ptr_q <= (steal_ptr_q == LAST) ? '0 : steal_ptr_q + 1'b1;
      end
    end
  end
`endif

  assign note         = note_q;
  assign velocity     = velocity_q;
  assign channel      = channel_q;
  assign addr         = addr_q;
  assign active_count = count_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator (128 voices); follows VOICE_STEAL_EN
// so the full-table case matches the build.
module tb_voice_allocator;

  logic       clk32 = 1'b0;
  logic       rst = 1'b1;
  logic       ev_valid = 1'b0;
  logic       ev_ready;
  logic [1:0] ev_type = 2'd0;
  logic [6:0] ev_note = '0;
  logic [6:0] ev_velocity = '0;
  logic [3:0] ev_channel = '0;
  logic       voice_done = 1'b0;
  logic [7:0] voice_done_addr = '0;
  logic       note_pressed, note_released, note_keypress, drop_pulse;
  logic [6:0] note, velocity;
  logic [3:0] channel;
  logic [7:0] addr, active_count;

  int checks = 0;
  int errors = 0;
  int multi = 0;

  logic       r_p, r_r, r_k, r_d;
  int         r_lat;
  logic [6:0] r_note, r_vel;
  logic [7:0] r_addr;

  always #5 clk32 = ~clk32;

  voice_allocator dut (
    .clk32          (clk32),
    .rst            (rst),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_type        (ev_type),
    .ev_note        (ev_note),
    .ev_velocity    (ev_velocity),
    .ev_channel     (ev_channel),
    .voice_done     (voice_done),
    .voice_done_addr(voice_done_addr),
    .note_pressed   (note_pressed),
    .note_released  (note_released),
    .note_keypress  (note_keypress),
    .note           (note),
    .velocity       (velocity),
    .channel        (channel),
    .addr           (addr),
    .active_count   (active_count),
    .drop_pulse     (drop_pulse)
  );

  always @(negedge clk32) begin
    if (int'(note_pressed) + int'(note_released) + int'(note_keypress) + int'(drop_pulse) > 1)
      multi++;
  end

  // Drives one event and records the first strobe/drop; optionally pulses voice_done
  // in the cycle that is done_at cycles after acceptance.
  task automatic send_ev(input logic [1:0] t, input logic [6:0] n, input logic [6:0] v,
                         input logic [3:0] c, input int done_at, input logic [7:0] d_addr);
    int k;
    k = 0;
    while (!ev_ready && k < 300) begin
      @(negedge clk32);
      k++;
    end
    if (!ev_ready) begin
      checks++;
      errors++;
      $display("FAIL ev_ready_wait: ev_ready=%b required 1", ev_ready);
    end
    ev_valid = 1'b1; ev_type = t; ev_note = n; ev_velocity = v; ev_channel = c;
    @(posedge clk32);
    @(negedge clk32);
    ev_valid = 1'b0;
    r_p = 0; r_r = 0; r_k = 0; r_d = 0; r_lat = 0; r_note = '0; r_vel = '0; r_addr = '0;
    voice_done_addr = d_addr;
    for (int i = 1; i <= 200; i++) begin
      voice_done = (i == done_at);
      if (note_pressed || note_released || note_keypress || drop_pulse) begin
        r_p = note_pressed; r_r = note_released; r_k = note_keypress; r_d = drop_pulse;
        r_lat = i; r_note = note; r_vel = velocity; r_addr = addr;
        break;
      end
      @(negedge clk32);
    end
    @(negedge clk32);
    voice_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk32);
    checks++;
    if (ev_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ev_ready); end
    checks++;
    if ({note_pressed, note_released, note_keypress, drop_pulse, note, velocity, channel, addr,
         active_count} !== '0) begin
      errors++;
      $display("FAIL rst_outputs: got addr=%0d note=%0d cnt=%0d want all 0", addr, note,
               active_count);
    end
    rst = 1'b0;
    @(negedge clk32);
    checks++;
    if (ev_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", ev_ready); end
  endtask

  task automatic test_first_note();
    send_ev(2'd0, 7'd60, 7'd100, 4'd0, 0, 8'd0);
    checks++;
    if ({r_p, r_r, r_k, r_d} !== 4'b1000 || r_addr !== 8'd0 || r_note !== 7'd60 ||
        r_vel !== 7'd100) begin
      errors++;
      $display("FAIL first_on: got strobes=%b addr=%0d note=%0d vel=%0d want 1000/0/60/100",
               {r_p, r_r, r_k, r_d}, r_addr, r_note, r_vel);
    end
    checks++;
    if (r_lat !== 129) begin errors++; $display("FAIL first_latency: got %0d want 129", r_lat); end
    checks++;
    if (active_count !== 8'd1) begin errors++; $display("FAIL first_count: got %0d want 1", active_count); end
  endtask

  task automatic test_note_off();
    send_ev(2'd0, 7'd60, 7'd80, 4'd1, 0, 8'd0);
    checks++;
    if (r_p !== 1'b1 || r_addr !== 8'd1) begin
      errors++; $display("FAIL second_on: got p=%b addr=%0d want 1/1", r_p, r_addr);
    end
    send_ev(2'd1, 7'd60, 7'd64, 4'd1, 0, 8'd0);
    checks++;
    if ({r_p, r_r, r_k, r_d} !== 4'b0100 || r_addr !== 8'd1 || r_lat !== 3) begin
      errors++;
      $display("FAIL off_hit: got strobes=%b addr=%0d lat=%0d want 0100/1/3",
               {r_p, r_r, r_k, r_d}, r_addr, r_lat);
    end
    send_ev(2'd1, 7'd60, 7'd64, 4'd1, 0, 8'd0);
    checks++;
    if ({r_p, r_r, r_k, r_d} !== 4'b0001 || r_lat !== 129) begin
      errors++;
      $display("FAIL off_miss: got strobes=%b lat=%0d want 0001/129", {r_p, r_r, r_k, r_d}, r_lat);
    end
    checks++;
    if (addr !== 8'd1 || note !== 7'd60 || channel !== 4'd1) begin
      errors++;
      $display("FAIL hold_fields: got addr=%0d note=%0d ch=%0d want 1/60/1", addr, note, channel);
    end
  endtask

  task automatic test_pressure_vel0();
    send_ev(2'd0, 7'd62, 7'd70, 4'd2, 0, 8'd0);
    checks++;
    if (r_p !== 1'b1 || r_addr !== 8'd2) begin
      errors++; $display("FAIL free_before_releasing: got p=%b addr=%0d want 1/2", r_p, r_addr);
    end
    send_ev(2'd0, 7'd64, 7'd70, 4'd2, 0, 8'd0);
    checks++;
    if (r_p !== 1'b1 || r_addr !== 8'd3) begin
      errors++; $display("FAIL slot3_on: got p=%b addr=%0d want 1/3", r_p, r_addr);
    end
    send_ev(2'd2, 7'd64, 7'd50, 4'd2, 0, 8'd0);
    checks++;
    if ({r_p, r_r, r_k, r_d} !== 4'b0010 || r_addr !== 8'd3 || r_vel !== 7'd50 || r_lat !== 5) begin
      errors++;
      $display("FAIL pressure: got strobes=%b addr=%0d vel=%0d lat=%0d want 0010/3/50/5",
               {r_p, r_r, r_k, r_d}, r_addr, r_vel, r_lat);
    end
    send_ev(2'd0, 7'd64, 7'd0, 4'd2, 0, 8'd0);
    checks++;
    if ({r_p, r_r, r_k, r_d} !== 4'b0100 || r_addr !== 8'd3 || r_vel !== 7'd0) begin
      errors++;
      $display("FAIL vel0_off: got strobes=%b addr=%0d vel=%0d want 0100/3/0",
               {r_p, r_r, r_k, r_d}, r_addr, r_vel);
    end
    checks++;
    if (active_count !== 8'd4) begin errors++; $display("FAIL count4: got %0d want 4", active_count); end
  endtask

  task automatic test_retrigger();
    send_ev(2'd0, 7'd60, 7'd90, 4'd0, 0, 8'd0);
    checks++;
    if (r_p !== 1'b1 || r_addr !== 8'd0 || r_lat !== 2 || r_vel !== 7'd90) begin
      errors++;
      $display("FAIL retrigger: got p=%b addr=%0d lat=%0d vel=%0d want 1/0/2/90",
               r_p, r_addr, r_lat, r_vel);
    end
    checks++;
    if (active_count !== 8'd4) begin errors++; $display("FAIL retrigger_count: got %0d want 4", active_count); end
  endtask

  task automatic test_ignored();
    int any;
    any = 0;
    ev_valid = 1'b1; ev_type = 2'd3; ev_note = 7'd10; ev_velocity = 7'd10; ev_channel = 4'd0;
    @(posedge clk32);
    @(negedge clk32);
    ev_valid = 1'b0;
    checks++;
    if (ev_ready !== 1'b1) begin errors++; $display("FAIL type3_ready: got %b want 1", ev_ready); end
    for (int i = 0; i < 5; i++) begin
      if (note_pressed || note_released || note_keypress || drop_pulse) any++;
      @(negedge clk32);
    end
    checks++;
    if (any !== 0) begin errors++; $display("FAIL type3_quiet: got %0d outputs want 0", any); end
  endtask

  task automatic test_reset_mid_scan();
    int any;
    any = 0;
    ev_valid = 1'b1; ev_type = 2'd0; ev_note = 7'd70; ev_velocity = 7'd100; ev_channel = 4'd5;
    @(posedge clk32);
    @(negedge clk32);
    ev_valid = 1'b0;
    repeat (20) @(negedge clk32);
    rst = 1'b1;
    #1;
    checks++;
    if (ev_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_low: got %b want 0", ev_ready); end
    @(negedge clk32);
    rst = 1'b0;
    @(negedge clk32);
    checks++;
    if (ev_ready !== 1'b1 || active_count !== 8'd0) begin
      errors++;
      $display("FAIL midrst_after: got ready=%b cnt=%0d want 1/0", ev_ready, active_count);
    end
    for (int i = 0; i < 150; i++) begin
      if (note_pressed || note_released || note_keypress || drop_pulse) any++;
      @(negedge clk32);
    end
    checks++;
    if (any !== 0) begin errors++; $display("FAIL midrst_no_strobe: got %0d want 0", any); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 128; i++) begin
      send_ev(2'd0, 7'(i), 7'd100, 4'd15, 0, 8'd0);
      checks++;
      if (r_p !== 1'b1 || r_addr !== 8'(i)) begin
        errors++; $display("FAIL fill_%0d: got p=%b addr=%0d want 1/%0d", i, r_p, r_addr, i);
      end
    end
    checks++;
    if (active_count !== 8'd128) begin errors++; $display("FAIL fill_count: got %0d want 128", active_count); end
  endtask

  task automatic test_full();
`ifdef VOICE_STEAL_EN
    send_ev(2'd0, 7'd0, 7'd99, 4'd14, 0, 8'd0);
    checks++;
    if ({r_p, r_r, r_k, r_d} !== 4'b1000 || r_addr !== 8'd0 || r_lat !== 129) begin
      errors++;
      $display("FAIL steal0: got strobes=%b addr=%0d lat=%0d want 1000/0/129",
               {r_p, r_r, r_k, r_d}, r_addr, r_lat);
    end
    send_ev(2'd0, 7'd1, 7'd99, 4'd14, 0, 8'd0);
    checks++;
    if ({r_p, r_r, r_k, r_d} !== 4'b1000 || r_addr !== 8'd1) begin
      errors++;
      $display("FAIL steal1: got strobes=%b addr=%0d want 1000/1", {r_p, r_r, r_k, r_d}, r_addr);
    end
`else
    for (int i = 0; i < 2; i++) begin
      send_ev(2'd0, 7'(i), 7'd99, 4'd14, 0, 8'd0);
      checks++;
      if ({r_p, r_r, r_k, r_d} !== 4'b0001 || r_lat !== 129) begin
        errors++;
        $display("FAIL full_drop_%0d: got strobes=%b lat=%0d want 0001/129", i,
                 {r_p, r_r, r_k, r_d}, r_lat);
      end
    end
`endif
    checks++;
    if (active_count !== 8'd128) begin errors++; $display("FAIL full_count: got %0d want 128", active_count); end
  endtask

  task automatic test_slot5();
    send_ev(2'd1, 7'd5, 7'd0, 4'd15, 0, 8'd0);
    checks++;
    if (r_r !== 1'b1 || r_addr !== 8'd5 || r_lat !== 7) begin
      errors++; $display("FAIL slot5_off: got r=%b addr=%0d lat=%0d want 1/5/7", r_r, r_addr, r_lat);
    end
    send_ev(2'd0, 7'd7, 7'd33, 4'd13, 129, 8'd5);
    checks++;
    if (r_p !== 1'b1 || r_addr !== 8'd5) begin
      errors++; $display("FAIL releasing_pick: got p=%b addr=%0d want 1/5", r_p, r_addr);
    end
    checks++;
    if (active_count !== 8'd128) begin errors++; $display("FAIL coincident_count: got %0d want 128", active_count); end
    send_ev(2'd1, 7'd7, 7'd0, 4'd13, 0, 8'd0);
    checks++;
    if (r_r !== 1'b1 || r_addr !== 8'd5) begin
      errors++; $display("FAIL issue_wins: got r=%b addr=%0d want 1/5", r_r, r_addr);
    end
    voice_done = 1'b1; voice_done_addr = 8'd5;
    @(negedge clk32);
    voice_done = 1'b0;
    @(negedge clk32);
    checks++;
    if (active_count !== 8'd127) begin errors++; $display("FAIL done_count: got %0d want 127", active_count); end
    voice_done = 1'b1; voice_done_addr = 8'd200;
    @(negedge clk32);
    voice_done = 1'b0;
    @(negedge clk32);
    checks++;
    if (active_count !== 8'd127) begin errors++; $display("FAIL done_oob: got %0d want 127", active_count); end
    send_ev(2'd0, 7'd0, 7'd44, 4'd12, 0, 8'd0);
    checks++;
    if (r_p !== 1'b1 || r_addr !== 8'd5 || active_count !== 8'd128) begin
      errors++;
      $display("FAIL refill5: got p=%b addr=%0d cnt=%0d want 1/5/128", r_p, r_addr, active_count);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (multi !== 0) begin errors++; $display("FAIL strobe_exclusive: got %0d cycles want 0", multi); end
  endtask

  initial begin
    test_reset();
    test_first_note();
    test_note_off();
    test_pressure_vel0();
    test_retrigger();
    test_ignored();
    test_reset_mid_scan();
    test_fill();
    test_full();
    test_slot5();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
